// File: rtl/checkpoint_rename_rf.sv
// Register-renaming file with a single map checkpoint: allocates physical names,
// forwards same-cycle writes, tracks readiness, and restores the map on rollback.
module checkpoint_rename_rf #(
   parameter int addr_width = 2,
   parameter int name_width = 3,
   parameter int data_width = 32,
   parameter int num_arch   = 4,
   parameter int num_phys   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [addr_width-1:0] ADDR_IN,
   input  logic                  ALLOC_E,
   output logic                  ALLOC_READY,
   output logic [name_width-1:0] NAME_OUT,
   input  logic [addr_width-1:0] ADDR_1,
   input  logic [addr_width-1:0] ADDR_2,
   output logic [name_width-1:0] NAME_OUT_1,
   output logic [name_width-1:0] NAME_OUT_2,
   input  logic [name_width-1:0] NAME_IN_1,
   input  logic [name_width-1:0] NAME_IN_2,
   input  logic [data_width-1:0] D_IN_1,
   input  logic [data_width-1:0] D_IN_2,
   input  logic                  WE_1,
   input  logic                  WE_2,
   input  logic [name_width-1:0] NAME_1,
   input  logic [name_width-1:0] NAME_2,
   output logic [data_width-1:0] D_OUT_1,
   output logic [data_width-1:0] D_OUT_2,
   input  logic [name_width-1:0] VALID_NAME_1,
   input  logic [name_width-1:0] VALID_NAME_2,
   output logic                  VALID_OUT_1,
   output logic                  VALID_OUT_2,
   input  logic [name_width-1:0] NAME_F,
   input  logic                  FE,
   input  logic                  CKPT_E,
   input  logic                  ROLLBACK_E,
   output logic                  CKPT_VALID
);

   logic [name_width-1:0] map_r  [num_arch];
   logic [name_width-1:0] snap_r [num_arch];
   logic [name_width-1:0] old_r  [num_phys];
   logic [data_width-1:0] phys_r [num_phys];
   logic [num_phys-1:0]   busy_r;
   logic [num_phys-1:0]   free_r;
   logic [num_phys-1:0]   since_r;
   logic                  ckpt_valid_r;

   logic [name_width:0]   free_sel_s;
   logic                  alloc_s;
   logic                  ckpt_s;
   logic                  rollback_s;

   // Priority encoder: {found, lowest set index}; all-zero when nothing is free.
   function automatic logic [name_width:0] lowest_free(input logic [num_phys-1:0] vec);
      logic [name_width:0] res;
      res = '0;
      for (int i = num_phys - 1; i >= 0; i--) begin
         res = vec[i] ? {1'b1, name_width'(i)} : res;
      end
      return res;
   endfunction

   assign free_sel_s  = lowest_free(free_r);
   assign ALLOC_READY = free_sel_s[name_width];
   assign NAME_OUT    = free_sel_s[name_width-1:0];
   assign NAME_OUT_1  = map_r[ADDR_1];
   assign NAME_OUT_2  = map_r[ADDR_2];
   assign CKPT_VALID  = ckpt_valid_r;

   // Rollback takes priority over both allocation and checkpointing.
   assign rollback_s = ROLLBACK_E & ckpt_valid_r;
   assign ckpt_s     = CKPT_E & ~ROLLBACK_E;
   assign alloc_s    = ALLOC_E & ALLOC_READY & ~ROLLBACK_E;

   // Data reads and readiness with write-port forwarding; port 1 wins a dual match.
   always_comb begin
      D_OUT_1     = phys_r[NAME_1];
      D_OUT_2     = phys_r[NAME_2];
      VALID_OUT_1 = ~busy_r[VALID_NAME_1];
      VALID_OUT_2 = ~busy_r[VALID_NAME_2];
      if (WE_1 && (NAME_IN_1 == NAME_1)) begin
         D_OUT_1 = D_IN_1;
      end else if (WE_2 && (NAME_IN_2 == NAME_1)) begin
         D_OUT_1 = D_IN_2;
      end else begin
         D_OUT_1 = phys_r[NAME_1];
      end
      if (WE_1 && (NAME_IN_1 == NAME_2)) begin
         D_OUT_2 = D_IN_1;
      end else if (WE_2 && (NAME_IN_2 == NAME_2)) begin
         D_OUT_2 = D_IN_2;
      end else begin
         D_OUT_2 = phys_r[NAME_2];
      end
      if ((WE_1 && (NAME_IN_1 == VALID_NAME_1)) || (WE_2 && (NAME_IN_2 == VALID_NAME_1))) begin
         VALID_OUT_1 = 1'b1;
      end else begin
         VALID_OUT_1 = ~busy_r[VALID_NAME_1];
      end
      if ((WE_1 && (NAME_IN_1 == VALID_NAME_2)) || (WE_2 && (NAME_IN_2 == VALID_NAME_2))) begin
         VALID_OUT_2 = 1'b1;
      end else begin
         VALID_OUT_2 = ~busy_r[VALID_NAME_2];
      end
   end

   // Rename state; later statements deliberately override earlier ones (write clears win).
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < num_arch; i++) begin
            map_r[i] <= name_width'(i);
         end
         for (int i = 0; i < num_phys; i++) begin
            free_r[i] <= (i >= num_arch);
         end
         busy_r       <= '0;
         since_r      <= '0;
         ckpt_valid_r <= 1'b0;
      end else begin
         if (rollback_s) begin
            map_r <= snap_r;
            for (int i = 0; i < num_phys; i++) begin
               if (since_r[i]) begin
                  free_r[i] <= 1'b1;
                  busy_r[i] <= 1'b0;
               end
            end
            since_r      <= '0;
            ckpt_valid_r <= 1'b0;
         end else if (ckpt_s) begin
            snap_r       <= map_r;
            since_r      <= '0;
            ckpt_valid_r <= 1'b1;
         end
         if (alloc_s) begin
            busy_r[NAME_OUT]  <= 1'b1;
            since_r[NAME_OUT] <= 1'b1;
            free_r[NAME_OUT]  <= 1'b0;
            old_r[NAME_OUT]   <= map_r[ADDR_IN];
            map_r[ADDR_IN]    <= NAME_OUT;
         end
         if (FE) begin
            free_r[old_r[NAME_F]] <= 1'b1;
         end
         if (WE_1) begin
            busy_r[NAME_IN_1] <= 1'b0;
         end
         if (WE_2) begin
            busy_r[NAME_IN_2] <= 1'b0;
         end
      end
   end

   // Physical data array, not reset; port 2 lands last so it wins on equal names.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (WE_1) begin
            phys_r[NAME_IN_1] <= D_IN_1;
         end
         if (WE_2) begin
            phys_r[NAME_IN_2] <= D_IN_2;
         end
      end
   end

endmodule
